fetch_decode: RTL and testbench

//  Instruction sequencer directly upstream of the ALU in the 8-bit core.

---
 rtl/fetch_decode_if.sv | 25 ++
 rtl/fetch_decode.sv | 161 ++++++++++++++++
 tb/tb_fetch_decode.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_decode_if.sv
// Memory, ALU and status bundle between the sequencer and the rest of the core.
interface fetch_decode_if;
  logic       run;
  logic [7:0] data_in;
  logic [7:0] addr;
  logic [7:0] data_out;
  logic       we;
  logic [7:0] a_out;
  logic [7:0] b_out;
  logic [7:0] alu_op;
  logic       alu_en;
  logic [7:0] alu_result;
  logic       halted;
  logic       illegal;

  modport master (
    input  run, data_in, alu_result,
    output addr, data_out, we, a_out, b_out, alu_op, alu_en, halted, illegal
  );

  modport slave (
    output run, data_in, alu_result,
    input  addr, data_out, we, a_out, b_out, alu_op, alu_en, halted, illegal
  );
endinterface

// File: rtl/fetch_decode.sv
// Instruction sequencer for the 8-bit core: fetches opcode/operand bytes,
// decodes them, runs loads/stores/jumps itself and hands ALU ops to the ALU.
module fetch_decode #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic           clk,
  input  logic           rst,
  fetch_decode_if.master bus
);
  localparam logic [2:0] S_FETCH   = 3'd0;
  localparam logic [2:0] S_DECODE  = 3'd1;
  localparam logic [2:0] S_OPERAND = 3'd2;
  localparam logic [2:0] S_EXEC    = 3'd3;
  localparam logic [2:0] S_STORE   = 3'd4;
  localparam logic [2:0] S_ALU     = 3'd5;
  localparam logic [2:0] S_HALT    = 3'd6;

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_LDA = 8'h01;
  localparam logic [7:0] OP_LDB = 8'h02;
  localparam logic [7:0] OP_STA = 8'h03;
  localparam logic [7:0] OP_JMP = 8'h04;
  localparam logic [7:0] OP_JZ  = 8'h05;
  localparam logic [7:0] OP_HLT = 8'hFF;

  logic [2:0] state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] inst_q, inst_d;
  logic [7:0] opnd_q, opnd_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic [7:0] alu_op_q, alu_op_d;
  logic [7:0] data_out_q, data_out_d;
  logic       we_q, we_d;
  logic       alu_en_q, alu_en_d;
  logic       halted_q, halted_d;
  logic       illegal_q, illegal_d;

  logic is_alu, has_opnd;

  // 0x10-0x17 go to the ALU; 0x01-0x05 carry one operand byte
  assign is_alu   = (bus.data_in[7:3] == 5'b00010);
  assign has_opnd = (bus.data_in >= OP_LDA) && (bus.data_in <= OP_JZ);

  // Next-state and datapath; strobes (we, alu_en, illegal) default low so they pulse
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    addr_d     = addr_q;
    inst_d     = inst_q;
    opnd_d     = opnd_q;
    a_d        = a_q;
    b_d        = b_q;
    alu_op_d   = alu_op_q;
    data_out_d = data_out_q;
    we_d       = 1'b0;
    alu_en_d   = 1'b0;
    halted_d   = 1'b0;
    illegal_d  = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (bus.run) begin
          addr_d  = pc_q;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        inst_d = bus.data_in;
        pc_d   = pc_q + 8'd1;
        addr_d = pc_q + 8'd1;
        if (has_opnd) begin
          state_d = S_OPERAND;
        end else if (is_alu) begin
          alu_op_d = bus.data_in;
          alu_en_d = 1'b1;
          state_d  = S_ALU;
        end else if (bus.data_in == OP_NOP) begin
          state_d = S_FETCH;
        end else if (bus.data_in == OP_HLT) begin
          halted_d = 1'b1;
          state_d  = S_HALT;
        end else begin
          illegal_d = 1'b1;
          state_d   = S_FETCH;
        end
      end
      S_OPERAND: begin
        opnd_d  = bus.data_in;
        pc_d    = pc_q + 8'd1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (inst_q)
          OP_LDA: a_d = opnd_q;
          OP_LDB: b_d = opnd_q;
          OP_JMP: pc_d = opnd_q;
          OP_JZ:  if (a_q == 8'h00) pc_d = opnd_q;
          OP_STA: begin
            addr_d     = opnd_q;
            data_out_d = a_q;
            we_d       = 1'b1;
            state_d    = S_STORE;
          end
          default: ;
        endcase
      end
      S_STORE: state_d = S_FETCH;
      S_ALU: begin
        a_d     = bus.alu_result;
        state_d = S_FETCH;
      end
      S_HALT: halted_d = 1'b1;
      default: state_d = S_FETCH;
    endcase
  end

  // State registers; async reset aborts any instruction in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      addr_q     <= RESET_PC;
      inst_q     <= 8'h00;
      opnd_q     <= 8'h00;
      a_q        <= 8'h00;
      b_q        <= 8'h00;
      alu_op_q   <= 8'h00;
      data_out_q <= 8'h00;
      we_q       <= 1'b0;
      alu_en_q   <= 1'b0;
      halted_q   <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      inst_q     <= inst_d;
      opnd_q     <= opnd_d;
      a_q        <= a_d;
      b_q        <= b_d;
      alu_op_q   <= alu_op_d;
      data_out_q <= data_out_d;
      we_q       <= we_d;
      alu_en_q   <= alu_en_d;
      halted_q   <= halted_d;
      illegal_q  <= illegal_d;
    end
  end

  assign bus.addr     = addr_q;
  assign bus.data_out = data_out_q;
  assign bus.we       = we_q;
  assign bus.a_out    = a_q;
  assign bus.b_out    = b_q;
  assign bus.alu_op   = alu_op_q;
  assign bus.alu_en   = alu_en_q;
  assign bus.halted   = halted_q;
  assign bus.illegal  = illegal_q;
endmodule

// File: tb/tb_fetch_decode.sv
// Bench for fetch_decode: byte memory + ALU stand-in around the DUT, checked
// cycle by cycle against an instruction-level reference interpreter.
module tb_fetch_decode;
  localparam logic [7:0] RST_PC = 8'h00;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk = 0;
  int   n_bad = 0;

  fetch_decode_if bus();

  fetch_decode #(.RESET_PC(RST_PC)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // environment memory (written by the DUT) and the model's own view of it
  logic [7:0] mem   [256];
  logic [7:0] m_mem [256];
  logic [7:0] m_pc, m_a, m_b, m_faddr;
  logic       m_ill;

  function automatic logic [7:0] alu_f(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op[2:0])
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ~a;
      3'd6: return a << 1;
      default: return a >> 1;
    endcase
  endfunction

  assign bus.data_in    = mem[bus.addr];
  assign bus.alu_result = bus.alu_en ? alu_f(bus.alu_op, bus.a_out, bus.b_out) : 8'h00;

  always @(posedge clk) if (bus.we) mem[bus.addr] <= bus.data_out;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic put(input logic [7:0] ad, input logic [7:0] v);
    mem[ad] = v;
    m_mem[ad] = v;
  endtask

  task automatic fill_halt();
    for (int i = 0; i < 256; i++) put(8'(i), 8'hFF);
  endtask

  task automatic model_reset();
    m_pc = RST_PC; m_a = 8'h00; m_b = 8'h00; m_ill = 1'b0; m_faddr = RST_PC;
  endtask

  task automatic chk_reset_vals();
    chk("rst_we", bus.we, 0);
    chk("rst_addr", bus.addr, RST_PC);
    chk("rst_a", bus.a_out, 0);
    chk("rst_b", bus.b_out, 0);
    chk("rst_dout", bus.data_out, 0);
    chk("rst_aluop", bus.alu_op, 0);
    chk("rst_aluen", bus.alu_en, 0);
    chk("rst_halt", bus.halted, 0);
    chk("rst_ill", bus.illegal, 0);
  endtask

  // leaves the bench at the negedge of the first FETCH cycle with run=1
  task automatic do_reset();
    tick();
    bus.run = 1'b0;
    rst = 1'b1;
    #1;
    chk_reset_vals();
    tick(); tick();
    rst = 1'b0;
    bus.run = 1'b1;
    model_reset();
  endtask

  // Execute up to n instructions. Cycle k of an instruction is the k-th negedge
  // after its FETCH cycle. hold_idx: stall run=0 for 5 cycles before that
  // instruction. rst_idx: if that instruction is STA, reset during its STORE.
  task automatic run_prog(input int n, input int hold_idx, input int rst_idx);
    logic [7:0] p, p1, op, opd;
    for (int i = 0; i < n; i++) begin
      chk("f_we", bus.we, 0);
      chk("f_aluen", bus.alu_en, 0);
      chk("f_ill", bus.illegal, m_ill);
      chk("f_addr", bus.addr, m_faddr);
      if (i == hold_idx) begin
        bus.run = 1'b0;
        repeat (5) begin
          tick();
          chk("hold_addr", bus.addr, m_faddr);
          chk("hold_ill", bus.illegal, 0);
          chk("hold_we", bus.we, 0);
        end
        bus.run = 1'b1;
      end
      tick();
      p = m_pc; p1 = p + 8'd1; op = m_mem[p];
      chk("d_addr", bus.addr, p);
      chk("d_a", bus.a_out, m_a);
      chk("d_b", bus.b_out, m_b);
      chk("d_halt", bus.halted, 0);
      chk("d_we", bus.we, 0);
      m_ill = 1'b0;
      if (op == 8'hFF) begin
        for (int k = 0; k < 5; k++) begin
          if (k == 3) bus.run = 1'b0;
          tick();
          chk("h_halt", bus.halted, 1);
          chk("h_we", bus.we, 0);
          chk("h_aluen", bus.alu_en, 0);
          chk("h_a", bus.a_out, m_a);
        end
        bus.run = 1'b1;
        return;
      end else if (op == 8'h00) begin
        m_pc = p1; m_faddr = p1;
      end else if (op >= 8'h10 && op <= 8'h17) begin
        tick();
        chk("alu_en", bus.alu_en, 1);
        chk("alu_op", bus.alu_op, op);
        chk("alu_we", bus.we, 0);
        m_a = alu_f(op, m_a, m_b);
        m_pc = p1; m_faddr = p1;
      end else if (op >= 8'h01 && op <= 8'h05) begin
        opd = m_mem[p1];
        tick();
        chk("o_we", bus.we, 0);
        chk("o_aluen", bus.alu_en, 0);
        tick();
        chk("x_we", bus.we, 0);
        m_pc = p1 + 8'd1; m_faddr = p1;
        case (op)
          8'h01: m_a = opd;
          8'h02: m_b = opd;
          8'h04: m_pc = opd;
          8'h05: if (m_a == 8'h00) m_pc = opd;
          default: begin
            tick();
            chk("st_we", bus.we, 1);
            chk("st_addr", bus.addr, opd);
            chk("st_dout", bus.data_out, m_a);
            if (i == rst_idx) begin
              rst = 1'b1;
              #1;
              chk("srst_we", bus.we, 0);
              chk("srst_addr", bus.addr, RST_PC);
              chk("srst_a", bus.a_out, 0);
              tick(); tick();
              rst = 1'b0;
              model_reset();
              return;
            end
            m_mem[opd] = m_a; m_faddr = opd;
          end
        endcase
      end else begin
        m_ill = 1'b1;
        m_pc = p1; m_faddr = p1;
      end
      tick();
    end
  endtask

  function automatic logic [7:0] rnd_byte();
    int k;
    k = $urandom_range(0, 99);
    if (k < 10) return 8'h00;
    if (k < 25) return 8'h01;
    if (k < 35) return 8'h02;
    if (k < 45) return 8'h03;
    if (k < 52) return 8'h04;
    if (k < 60) return 8'h05;
    if (k < 85) return 8'h10 + 8'($urandom_range(0, 7));
    if (k < 87) return 8'hFF;
    return 8'($urandom_range(0, 255));
  endfunction

  initial begin
    bus.run = 1'b0;

    // reset during STORE, then re-run from RESET_PC
    do_reset();
    fill_halt();
    put(8'h00, 8'h01); put(8'h01, 8'hAA); put(8'h02, 8'h03); put(8'h03, 8'h40);
    run_prog(5, -1, 1);
    chk("srst_nowrite", mem[8'h40], 8'hFF);
    run_prog(5, -1, -1);
    chk("st_mem", mem[8'h40], 8'hAA);

    // LDA/LDB/ADD/HLT
    do_reset();
    fill_halt();
    put(8'h00, 8'h01); put(8'h01, 8'h05); put(8'h02, 8'h02); put(8'h03, 8'h03);
    put(8'h04, 8'h10); put(8'h05, 8'hFF);
    run_prog(10, -1, -1);
    chk("add_a", bus.a_out, 8'h08);
    chk("add_b", bus.b_out, 8'h03);

    // JZ taken (A=0) and not taken (A=1)
    do_reset();
    fill_halt();
    put(8'h00, 8'h01); put(8'h01, 8'h00); put(8'h02, 8'h05); put(8'h03, 8'h20);
    put(8'h20, 8'h00);
    run_prog(5, -1, -1);
    do_reset();
    fill_halt();
    put(8'h00, 8'h01); put(8'h01, 8'h01); put(8'h02, 8'h05); put(8'h03, 8'h20);
    put(8'h04, 8'h00);
    run_prog(5, -1, -1);

    // JMP FE, LDA with operand at FF, wrap to 00
    do_reset();
    fill_halt();
    put(8'h00, 8'h04); put(8'h01, 8'hFE); put(8'hFE, 8'h01); put(8'hFF, 8'h77);
    run_prog(3, -1, -1);
    chk("wrap_a", bus.a_out, 8'h77);

    // illegal opcode, then a 5-cycle run=0 hold
    do_reset();
    fill_halt();
    put(8'h00, 8'h20); put(8'h01, 8'h00);
    run_prog(4, 1, -1);

    // random programs
    for (int r = 0; r < 8; r++) begin
      do_reset();
      for (int i = 0; i < 256; i++) put(8'(i), rnd_byte());
      run_prog(30, $urandom_range(0, 29), -1);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
